// File: rtl/ram_bridge_pkg.sv
// Shared types and constants for the Z80/DMA to SDRAM request bridge.
package ram_bridge_pkg;

    localparam int unsigned ADDR_W_DEF   = 19;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned WDOG_W       = 8;
    localparam logic [7:0]  TIMEOUT_FILL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        DMA_ACC,
        CPU_HOLD,
        DMA_HOLD
    } state_e;

    function automatic logic is_acc(input state_e s);
        return (s == CPU_ACC) || (s == DMA_ACC);
    endfunction

endpackage

// File: rtl/ram_bridge_watchdog.sv
// Transaction watchdog: counts cycles while a request is outstanding and flags expiry.
module ram_bridge_watchdog
    import ram_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic nReset,
    input  logic run,
    output logic expire_c
);

    logic [WDOG_W-1:0] cnt_q;

    // Saturating count, cleared whenever no transaction is in flight.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + WDOG_W'(1);
        end
    end

    // Fires in the LIMIT-th cycle of the request so sd_req is high for exactly LIMIT clocks.
    assign expire_c = run && (cnt_q == WDOG_W'(LIMIT - 1));

endmodule

// File: rtl/ram_bridge.sv
// Z80/DMA request bridge to the SDRAM controller: one req/ack transaction per strobe.
// Optional watchdog abort enabled by defining RAM_BRIDGE_TIMEOUT_EN.
module ram_bridge
    import ram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_assert,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rd,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic              sd_ack,
    input  logic [DATA_W-1:0] sd_rdata,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic              sd_req_d, sd_we_d;
    logic [ADDR_W-1:0] sd_addr_d;
    logic [DATA_W-1:0] sd_wdata_d, cpu_rdata_d, dma_rdata_d, rd_val;
    logic              cpu_ready_d, dma_done_d, timeout_err_d;
    logic              cpu_strobe, dma_strobe, in_acc, expire_c, done_ev;

    assign cpu_strobe = cpu_rd | cpu_we;
    assign dma_strobe = dma_rd | dma_we;
    assign in_acc     = is_acc(state_q);

`ifdef RAM_BRIDGE_TIMEOUT_EN
    ram_bridge_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .nReset   (nReset),
        .run      (in_acc),
        .expire_c (expire_c)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign expire_c           = 1'b0;
`endif

    // A real ack wins over a same-cycle expiry; an abort returns the fill pattern.
    assign done_ev = sd_ack | expire_c;
    assign rd_val  = sd_ack ? sd_rdata : DATA_W'(TIMEOUT_FILL);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        sd_req_d      = sd_req;
        sd_we_d       = sd_we;
        sd_addr_d     = sd_addr;
        sd_wdata_d    = sd_wdata;
        cpu_rdata_d   = cpu_rdata;
        dma_rdata_d   = dma_rdata;
        cpu_ready_d   = !cpu_strobe;
        dma_done_d    = 1'b0;
        timeout_err_d = timeout_err | (in_acc & expire_c & !sd_ack);

        case (state_q)
            IDLE: begin
                if (dma_assert && dma_strobe) begin
                    state_d    = DMA_ACC;
                    sd_req_d   = 1'b1;
                    sd_we_d    = dma_we;
                    sd_addr_d  = dma_addr;
                    sd_wdata_d = dma_wdata;
                end else if (!dma_assert && cpu_strobe) begin
                    state_d    = CPU_ACC;
                    sd_req_d   = 1'b1;
                    sd_we_d    = cpu_we;
                    sd_addr_d  = cpu_addr;
                    sd_wdata_d = cpu_wdata;
                end
            end
            CPU_ACC: begin
                cpu_ready_d = 1'b0;
                if (done_ev) begin
                    state_d     = CPU_HOLD;
                    sd_req_d    = 1'b0;
                    cpu_ready_d = 1'b1;
                    if (!sd_we) begin
                        cpu_rdata_d = rd_val;
                    end
                end
            end
            DMA_ACC: begin
                if (done_ev) begin
                    state_d    = DMA_HOLD;
                    sd_req_d   = 1'b0;
                    dma_done_d = 1'b1;
                    if (!sd_we) begin
                        dma_rdata_d = rd_val;
                    end
                end
            end
            CPU_HOLD: begin
                // Access already served; the CPU may run while it releases its strobe.
                cpu_ready_d = 1'b1;
                if (!cpu_strobe) begin
                    state_d = IDLE;
                end
            end
            DMA_HOLD: begin
                if (!dma_strobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                sd_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops sd_req asynchronously.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            sd_req      <= 1'b0;
            sd_we       <= 1'b0;
            sd_addr     <= '0;
            sd_wdata    <= '0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            cpu_ready   <= 1'b1;
            dma_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            sd_req      <= sd_req_d;
            sd_we       <= sd_we_d;
            sd_addr     <= sd_addr_d;
            sd_wdata    <= sd_wdata_d;
            cpu_rdata   <= cpu_rdata_d;
            dma_rdata   <= dma_rdata_d;
            cpu_ready   <= cpu_ready_d;
            dma_done    <= dma_done_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: doc/ram_bridge.md
# ram_bridge

Request bridge between the Z80 memory/bank interface and the SDRAM controller. It turns the CPU's level-sensitive read/write strobes and the DMA port into single req/ack transactions to the controller. It latches the address and write data for each transaction, captures read data, and produces the CPU wait/ready handshake. DMA has priority over the CPU but never preempts a transaction already in flight.

## Interface
Parameters:
- ADDR_W, 19, physical RAM address width (6-bit bank + 13-bit offset)
- DATA_W, 8, data width
- TIMEOUT_CYCLES, 255, watchdog limit (used only with RAM_BRIDGE_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-low; ports are named clk and nReset):
- clk  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_W  banked CPU address
- cpu_rd  in  1  CPU read strobe, active-high level
- cpu_we  in  1  CPU write strobe, active-high level
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  last CPU read result
- cpu_ready  out  1  1 = no CPU access pending; 0 = CPU must wait
- dma_assert  in  1  DMA owns the bus
- dma_addr  in  ADDR_W  DMA address
- dma_rd  in  1  DMA read request, level
- dma_we  in  1  DMA write request, level
- dma_wdata  in  DATA_W  DMA write data
- dma_rdata  out  DATA_W  last DMA read result
- dma_done  out  1  one-cycle pulse when a DMA access completes
- sd_req  out  1  request to SDRAM controller, level
- sd_we  out  1  1 = write, 0 = read
- sd_addr  out  ADDR_W  transaction address
- sd_wdata  out  DATA_W  transaction write data
- sd_ack  in  1  one-cycle completion pulse from the controller
- sd_rdata  in  DATA_W  read data, valid in the sd_ack cycle
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - CPU_ACC: CPU transaction in flight.
  - DMA_ACC: DMA transaction in flight.
  - CPU_HOLD: CPU access complete; waiting for its strobes to drop.
  - DMA_HOLD: DMA access complete; waiting for its requests to drop.
- IDLE transitions:
  - If dma_assert and (dma_rd or dma_we): go to DMA_ACC.
  - Otherwise, if !dma_assert and (cpu_rd or cpu_we): go to CPU_ACC.
  - A simultaneous request resolves to DMA when dma_assert=1.
- On entering an ACC state: sd_addr, sd_we and sd_wdata are latched from the winning source and sd_req=1. If write and read are both asserted, write wins.
- ACC transitions on sd_ack:
  - Read data is captured into cpu_rdata or dma_rdata.
  - sd_req goes to 0.
  - The FSM moves to the matching HOLD state.
- HOLD transitions: return to IDLE once both strobes of that source are 0. This guarantees one transaction per CPU strobe assertion.
- cpu_ready is 0 from the cycle after a CPU strobe is seen until the cycle after sd_ack. It is also 0 while a CPU strobe is blocked by dma_assert or by a DMA transaction in flight.
- dma_done pulses in the cycle after sd_ack of a DMA transaction.
- dma_assert dropping mid-DMA transaction does not abort it.

## Timing
- Reset values: all outputs 0 except cpu_ready=1. FSM starts in IDLE.
- Reset mid-transaction: sd_req drops immediately (asynchronously). The controller tolerates an abandoned request.
- Request latency: sd_req rises 1 clk after the strobe is sampled in IDLE.
- sd_addr, sd_we and sd_wdata are stable from sd_req rise until the cycle after sd_ack.
- Minimum one clk between consecutive sd_req pulses (the HOLD/IDLE pass).
- sd_ack arriving while not in an ACC state is ignored.
- cpu_rdata and dma_rdata hold their value until the next read of the same source completes.

## Configuration
- RAM_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit counter runs while in an ACC state.
  - When it reaches TIMEOUT_CYCLES without sd_ack, the transaction is aborted: sd_req=0, read data = 8'hFF, timeout_err=1 (sticky until reset), and the FSM proceeds to HOLD as if acked.
- Undefined: the bridge waits indefinitely and timeout_err is tied to 0.

## Structure
- Package ram_bridge_pkg holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - TIMEOUT_FILL = 8'hFF.
- One sub-module, ram_bridge_watchdog (counter plus expiry pulse), is instantiated only under RAM_BRIDGE_TIMEOUT_EN.

## Test plan
- CPU read: cpu_rd=1, cpu_addr=19'h0A123, sd_ack 4 clks after sd_req with sd_rdata=8'h5A -> sd_we=0, sd_addr=19'h0A123, cpu_rdata=8'h5A, cpu_ready returns to 1 exactly one clk after sd_ack, single sd_req pulse while cpu_rd is held.
- CPU write: cpu_we=1, cpu_wdata=8'hC3, cpu_addr=19'h7FFFF -> sd_we=1, sd_wdata=8'hC3, sd_addr=19'h7FFFF; cpu_rdata unchanged.
- Simultaneous CPU and DMA: dma_assert=1 with dma_rd at 19'h00010 and cpu_rd in the same cycle -> DMA transaction first with a dma_done pulse; cpu_ready=0 throughout; the CPU transaction issues after dma_assert drops.
- Reset mid-transaction: nReset low while sd_req=1 -> sd_req=0 immediately, cpu_ready=1, FSM in IDLE; a late sd_ack after reset is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=16): cpu_rd with no sd_ack -> abort after 16 clks, cpu_rdata=8'hFF, timeout_err=1 and still 1 after a subsequent normal access.
